// File: rtl/mc_pkg.sv
// mc_pkg: state, ALU, opcode and select encodings shared by the multicycle controller
package mc_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;
  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_JR
  } iclass_t;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;
  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_PC4 = 2'd2;
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_NPC   = 2'd1;
  localparam logic [1:0] PC_RD1   = 2'd2;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: classifies op/funct into an instruction class and a legal flag
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       legal
);
  assign iclass = (op == OP_R)   ? ((funct == FN_SUBU) ? I_SUBU : (funct == FN_JR) ? I_JR : I_ADDU) :
                  (op == OP_ORI) ? I_ORI :
                  (op == OP_LUI) ? I_LUI :
                  (op == OP_LW)  ? I_LW  :
                  (op == OP_SW)  ? I_SW  :
                  (op == OP_BEQ) ? I_BEQ :
                  (op == OP_J)   ? I_J   :
                  (op == OP_JAL) ? I_JAL : I_ADDU;
  assign legal = (op == OP_R) ? (funct == FN_ADDU || funct == FN_SUBU || funct == FN_JR) :
                 (op == OP_ORI || op == OP_LUI || op == OP_LW || op == OP_SW ||
                  op == OP_BEQ || op == OP_J || op == OP_JAL);
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS sequencing FSM; MULTICYCLE_CTRL_PERF_EN adds CycleCnt/InstrCnt
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Equal,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [3:0]       ALUOp,
  output logic [1:0]       ExtOp,
  output logic             ALUSrc,
  output logic [1:0]       RegDst,
  output logic [1:0]       RegSrc,
  output logic [1:0]       PCSrc,
  output logic             NPCOp,
  output logic [2:0]       State,
  output logic             Illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InstrCnt
`endif
);
  state_t  state, nxt;
  iclass_t ic;
  logic    legal, is_r, is_mem, is_jmp;
  mc_decode u_dec (.op(Op), .funct(Funct), .iclass(ic), .legal(legal));
  assign is_r   = ic == I_ADDU || ic == I_SUBU;
  assign is_mem = ic == I_LW || ic == I_SW;
  assign is_jmp = ic == I_J || ic == I_JAL || ic == I_JR || ic == I_BEQ;
  assign State  = state;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state <= S_FETCH;
    else        state <= nxt;
  always_comb begin
    nxt      = state;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUOp    = ALU_ADD;
    ExtOp    = EXT_ZERO;
    ALUSrc   = 1'b0;
    RegDst   = DST_RT;
    RegSrc   = SRC_ALU;
    PCSrc    = PC_PLUS4;
    NPCOp    = 1'b0;
    Illegal  = 1'b0;
    if (Reset)
      case (state)
        S_FETCH: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          nxt     = S_DECODE;
        end
        S_DECODE: begin
          PCWrite  = ic == I_J || ic == I_JAL || ic == I_JR || (ic == I_BEQ && Equal);
          PCSrc    = (ic == I_JR) ? PC_RD1 : (ic == I_J || ic == I_JAL || ic == I_BEQ) ? PC_NPC : PC_PLUS4;
          NPCOp    = ic == I_BEQ;
          RegWrite = ic == I_JAL;
          RegDst   = (ic == I_JAL) ? DST_RA : DST_RT;
          RegSrc   = (ic == I_JAL) ? SRC_PC4 : SRC_ALU;
          nxt      = !legal ? S_TRAP : is_jmp ? S_FETCH : S_EXEC;
        end
        S_EXEC: begin
          ALUOp  = (ic == I_SUBU) ? ALU_SUB : (ic == I_ORI) ? ALU_OR : ALU_ADD;
          ALUSrc = !is_r;
          ExtOp  = (ic == I_LUI) ? EXT_UPPER : is_mem ? EXT_SIGN : EXT_ZERO;
          nxt    = is_mem ? S_MEM : S_WB;
        end
        S_MEM: begin
          MemRead  = ic == I_LW;
          MemWrite = ic == I_SW;
          nxt      = !MemReady ? S_MEM : (ic == I_LW) ? S_WB : S_FETCH;
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst   = is_r ? DST_RD : DST_RT;
          RegSrc   = (ic == I_LW) ? SRC_MEM : SRC_ALU;
          nxt      = S_FETCH;
        end
        S_TRAP:  Illegal = 1'b1;
        default: nxt = S_FETCH;
      endcase
  end
`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      CycleCnt <= '0;
      InstrCnt <= '0;
    end else begin
      if (state != S_TRAP) CycleCnt <= CycleCnt + CNT_W'(1);
      if (nxt == S_FETCH && (state == S_DECODE || state == S_MEM || state == S_WB))
        InstrCnt <= InstrCnt + CNT_W'(1);
    end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif
endmodule
